// File: rtl/tap_pkg.sv
// tap_pkg: shared definitions for the JTAG TAP controller.
//  - tap_state_e : 16-state TAP FSM, 4-bit encoding
//  - IrWDefault  : default instruction register width
//  - Op*Val      : opcode values; the top casts them to its IR width (BYPASS is all ones)
//  - IrCapture   : pattern loaded into the IR shift stage in Capture-IR
package tap_pkg;

  localparam int unsigned IrWDefault = 4;

  typedef enum logic [3:0] {
    StTlr   = 4'hF,
    StRti   = 4'hC,
    StSelDr = 4'h7,
    StCapDr = 4'h6,
    StShDr  = 4'h2,
    StEx1Dr = 4'h1,
    StPauDr = 4'h3,
    StEx2Dr = 4'h0,
    StUpdDr = 4'h5,
    StSelIr = 4'h4,
    StCapIr = 4'hE,
    StShIr  = 4'hA,
    StEx1Ir = 4'h9,
    StPauIr = 4'hB,
    StEx2Ir = 4'h8,
    StUpdIr = 4'hD
  } tap_state_e;

  localparam int unsigned OpExtestVal = 0;
  localparam int unsigned OpSampleVal = 1;
  localparam int unsigned OpIdcodeVal = 2;

  localparam logic [1:0] IrCapture = 2'b01;

endpackage

// File: rtl/tap_controller_if.sv
// tap_controller_if: JTAG pins plus the boundary-scan chain control bundle.
//  TMS, TDI      : test mode select / serial data in (TDI also feeds the boundary chain head)
//  bsc_tdo       : serial out of the last boundary scan cell
//  ShiftDR, ClockDR, UpdateDR, Mode : boundary chain controls
//  TDO, TDO_en   : serial data out and its enable
// Modports: master = tester / chain side, slave = TAP controller.
interface tap_controller_if;
  logic TMS;
  logic TDI;
  logic bsc_tdo;
  logic ShiftDR;
  logic ClockDR;
  logic UpdateDR;
  logic Mode;
  logic TDO;
  logic TDO_en;

  modport master (
    output TMS, TDI, bsc_tdo,
    input  ShiftDR, ClockDR, UpdateDR, Mode, TDO, TDO_en
  );

  modport slave (
    input  TMS, TDI, bsc_tdo,
    output ShiftDR, ClockDR, UpdateDR, Mode, TDO, TDO_en
  );
endinterface

// File: rtl/tap_fsm.sv
// tap_fsm: IEEE 1149.1 16-state TAP state machine.
//  TCK          : clock, all state on posedge
//  TRST_n       : synchronous active-low reset to Test-Logic-Reset
//  i_tms        : test mode select
//  o_state      : registered current state
//  o_state_next : next state selected by TMS (reset not included)
module tap_fsm
  import tap_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST_n,
  input  logic       i_tms,
  output tap_state_e o_state,
  output tap_state_e o_state_next
);

  tap_state_e r_state;
  tap_state_e w_state_next;

  always_ff @(posedge TCK) begin
    if (!TRST_n) begin
      r_state <= StTlr;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StTlr:   w_state_next = i_tms ? StTlr   : StRti;
      StRti:   w_state_next = i_tms ? StSelDr : StRti;
      StSelDr: w_state_next = i_tms ? StSelIr : StCapDr;
      StCapDr: w_state_next = i_tms ? StEx1Dr : StShDr;
      StShDr:  w_state_next = i_tms ? StEx1Dr : StShDr;
      StEx1Dr: w_state_next = i_tms ? StUpdDr : StPauDr;
      StPauDr: w_state_next = i_tms ? StEx2Dr : StPauDr;
      StEx2Dr: w_state_next = i_tms ? StUpdDr : StShDr;
      StUpdDr: w_state_next = i_tms ? StSelDr : StRti;
      StSelIr: w_state_next = i_tms ? StTlr   : StCapIr;
      StCapIr: w_state_next = i_tms ? StEx1Ir : StShIr;
      StShIr:  w_state_next = i_tms ? StEx1Ir : StShIr;
      StEx1Ir: w_state_next = i_tms ? StUpdIr : StPauIr;
      StPauIr: w_state_next = i_tms ? StEx2Ir : StPauIr;
      StEx2Ir: w_state_next = i_tms ? StUpdIr : StShIr;
      StUpdIr: w_state_next = i_tms ? StSelDr : StRti;
      default: w_state_next = StTlr;
    endcase
  end

  assign o_state      = r_state;
  assign o_state_next = w_state_next;

endmodule

// File: rtl/tap_controller.sv
// tap_controller: JTAG TAP for the ripple-adder boundary-scan wrapper.
//  Holds the TAP FSM (tap_fsm), instruction register, bypass register, optional IDCODE
//  register, instruction decode and the TDO mux. Single TCK domain; ClockDR/UpdateDR are
//  one-cycle enables, not clocks.
// Parameters: IR_W (instruction width, >=2), IDCODE_VAL (device ID, bit0 = 1).
// Ports:
//  TCK    : clock
//  TRST_n : synchronous active-low reset
//  bus    : tap_controller_if.slave (TMS, TDI, bsc_tdo in; ShiftDR, ClockDR, UpdateDR,
//           Mode, TDO, TDO_en out)
// Configuration: define TAP_IDCODE_EN to add the 32-bit IDCODE register and make IDCODE the
//  reset instruction; otherwise opcode IDCODE decodes as BYPASS and BYPASS is the default.
module tap_controller
  import tap_pkg::*;
#(
  parameter int unsigned IR_W       = IrWDefault,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0A5B
) (
  input  logic             TCK,
  input  logic             TRST_n,
  tap_controller_if.slave  bus
);

  localparam logic [IR_W-1:0] OpExtest = IR_W'(OpExtestVal);
  localparam logic [IR_W-1:0] OpSample = IR_W'(OpSampleVal);
  localparam logic [IR_W-1:0] OpIdcode = IR_W'(OpIdcodeVal);
  localparam logic [IR_W-1:0] OpBypass = '1;

`ifdef TAP_IDCODE_EN
  localparam logic [IR_W-1:0] IrDefault = OpIdcode;
`else
  localparam logic [IR_W-1:0] IrDefault = OpBypass;
`endif

  tap_state_e w_state;
  tap_state_e w_state_next;

  tap_fsm u_fsm (
    .TCK          (TCK),
    .TRST_n       (TRST_n),
    .i_tms        (bus.TMS),
    .o_state      (w_state),
    .o_state_next (w_state_next)
  );

  logic [IR_W-1:0] r_ir;
  logic [IR_W-1:0] r_ir_sh;
  logic            r_bypass;

  // Instruction decode; unknown opcodes fall through to bypass.
  logic w_is_extest;
  logic w_is_sample;
  logic w_is_idcode;
  logic w_bsr_sel;
  logic w_id_bit;

  assign w_is_extest = (r_ir == OpExtest);
  assign w_is_sample = (r_ir == OpSample);
  assign w_bsr_sel   = w_is_extest | w_is_sample;

  always_ff @(posedge TCK) begin
    if (!TRST_n) begin
      r_ir     <= IrDefault;
      r_ir_sh  <= '0;
      r_bypass <= 1'b0;
    end else begin
      case (w_state)
        StCapIr: r_ir_sh <= IR_W'(IrCapture);
        StShIr:  r_ir_sh <= {bus.TDI, r_ir_sh[IR_W-1:1]};
        default: ;
      endcase

      case (w_state)
        StCapDr: r_bypass <= 1'b0;
        StShDr:  r_bypass <= bus.TDI;
        default: ;
      endcase

      // Entering Test-Logic-Reset restores the default instruction, same as TRST_n.
      if (w_state_next == StTlr) begin
        r_ir <= IrDefault;
      end else if (w_state == StUpdIr) begin
        r_ir <= r_ir_sh;
      end
    end
  end

`ifdef TAP_IDCODE_EN
  logic [31:0] r_id_sh;

  assign w_is_idcode = (r_ir == OpIdcode);
  assign w_id_bit    = r_id_sh[0];

  always_ff @(posedge TCK) begin
    if (!TRST_n) begin
      r_id_sh <= '0;
    end else if (w_is_idcode) begin
      if (w_state == StCapDr) begin
        r_id_sh <= IDCODE_VAL;
      end else if (w_state == StShDr) begin
        r_id_sh <= {bus.TDI, r_id_sh[31:1]};
      end
    end
  end
`else
  assign w_is_idcode = 1'b0;
  assign w_id_bit    = 1'b0;
`endif

  logic w_tdo;

  always_comb begin
    w_tdo = 1'b0;
    case (w_state)
      StShIr: w_tdo = r_ir_sh[0];
      StShDr: begin
        if (w_bsr_sel) begin
          w_tdo = bus.bsc_tdo;
        end else if (w_is_idcode) begin
          w_tdo = w_id_bit;
        end else begin
          w_tdo = r_bypass;
        end
      end
      default: w_tdo = 1'b0;
    endcase
  end

  assign bus.ShiftDR  = (w_state == StShDr) & w_bsr_sel;
  assign bus.ClockDR  = ((w_state == StCapDr) | (w_state == StShDr)) & w_bsr_sel;
  assign bus.UpdateDR = (w_state == StUpdDr) & w_bsr_sel;
  assign bus.Mode     = w_is_extest & (w_state != StTlr);
  assign bus.TDO_en   = (w_state == StShDr) | (w_state == StShIr);
  assign bus.TDO      = w_tdo;

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: stimulus pushes expected outputs from a reference
// model into a queue; a negedge monitor pops and compares. Directed scenarios plus a random walk.
module tb_tap_controller;

  localparam logic [31:0] IdVal = 32'h1000_0A5B;
`ifdef TAP_IDCODE_EN
  localparam bit IdEn = 1'b1;
`else
  localparam bit IdEn = 1'b0;
`endif

  // Reference-model state numbering (independent of the RTL encoding).
  localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7;
  localparam int UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14;
  localparam int UIR = 15;
  localparam int Nxt0[16] = '{RTI, RTI, CDR, SHDR, SHDR, PDR, PDR, SHDR,
                              RTI, CIR, SHIR, SHIR, PIR, PIR, SHIR, RTI};
  localparam int Nxt1[16] = '{TLR, SDR, SIR, E1DR, E1DR, UDR, E2DR, UDR,
                              SDR, TLR, E1IR, E1IR, UIR, E2IR, UIR, SDR};

  logic tck;
  logic trst_n;
  tap_controller_if u_if ();

  tap_controller u_dut (
    .TCK    (tck),
    .TRST_n (trst_n),
    .bus    (u_if)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt_shift, cnt_clock, cnt_upd;

  // Model state
  int         m_st    = TLR;
  bit         m_known = 1'b0;
  logic [3:0] m_ir, m_irsh;
  bit         m_byp;
  logic [31:0] m_id;

  logic [5:0] exp_q[$];

  function automatic logic [3:0] ir_def();
    return IdEn ? 4'b0010 : 4'b1111;
  endfunction

  // {TDO_en, TDO, ShiftDR, ClockDR, UpdateDR, Mode}
  function automatic logic [5:0] model_out(bit bsc);
    bit bsr, idsel, tdo;
    bsr   = (m_ir == 4'd0) || (m_ir == 4'd1);
    idsel = IdEn && (m_ir == 4'd2);
    tdo   = 1'b0;
    if (m_st == SHIR) tdo = m_irsh[0];
    if (m_st == SHDR) tdo = bsr ? bsc : (idsel ? m_id[0] : m_byp);
    return {(m_st == SHDR) || (m_st == SHIR), tdo,
            bsr && (m_st == SHDR),
            bsr && ((m_st == CDR) || (m_st == SHDR)),
            bsr && (m_st == UDR),
            (m_ir == 4'd0) && (m_st != TLR)};
  endfunction

  task automatic model_clk(bit tn, bit tms, bit tdi);
    bit idsel;
    idsel = IdEn && (m_ir == 4'd2);
    if (!tn) begin
      m_st = TLR; m_irsh = '0; m_byp = 1'b0; m_ir = ir_def(); m_known = 1'b1;
      return;
    end
    if (!m_known) return;
    case (m_st)
      CIR:  m_irsh = 4'b0001;
      SHIR: m_irsh = {tdi, m_irsh[3:1]};
      UIR:  m_ir = m_irsh;
      CDR: begin
        m_byp = 1'b0;
        if (idsel) m_id = IdVal;
      end
      SHDR: begin
        m_byp = tdi;
        if (idsel) m_id = {tdi, m_id[31:1]};
      end
      default: ;
    endcase
    m_st = tms ? Nxt1[m_st] : Nxt0[m_st];
    if (m_st == TLR) m_ir = ir_def();
  endtask

  // Monitor: compare every presented cycle against the scoreboard head.
  always @(negedge tck) begin
    logic [5:0] got, want;
    got = {u_if.TDO_en, u_if.TDO, u_if.ShiftDR, u_if.ClockDR, u_if.UpdateDR, u_if.Mode};
    cnt_shift += int'(u_if.ShiftDR === 1'b1);
    cnt_clock += int'(u_if.ClockDR === 1'b1);
    cnt_upd   += int'(u_if.UpdateDR === 1'b1);
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL outs t=%0t {en,tdo,sh,ck,up,mode} got=%b want=%b", $time, got, want);
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", name, got, want);
  endtask

  // One TCK cycle; starts and ends 1 time unit after a posedge.
  task automatic cyc(input bit tn, input bit tms, input bit tdi, output bit tdo_seen);
    bit bsc;
    bsc = 1'($urandom_range(0, 1));
    trst_n = tn; u_if.TMS = tms; u_if.TDI = tdi; u_if.bsc_tdo = bsc;
    if (m_known) exp_q.push_back(model_out(bsc));
    #2 tdo_seen = u_if.TDO;
    @(posedge tck);
    model_clk(tn, tms, tdi);
    #1;
  endtask

  task automatic c(input bit tms);
    bit t;
    cyc(1'b1, tms, 1'($urandom_range(0, 1)), t);
  endtask

  task automatic do_reset(int n);
    bit t;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t);
  endtask

  task automatic goto_rti();
    for (int i = 0; i < 5; i++) c(1'b1);
    c(1'b0);
  endtask

  // From RTI: load an instruction, return to RTI. Returns first two captured TDO bits.
  task automatic load_ir(input logic [3:0] op, output logic [1:0] cap);
    bit t;
    c(1'b1); c(1'b1); c(1'b0); c(1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, i == 3, op[i], t);
      if (i < 2) cap[i] = t;
    end
    c(1'b1); c(1'b0);
  endtask

  // From RTI: CapDR then n ShDR cycles with given TDI bits; collects TDO; returns to RTI.
  task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
    bit t;
    dout = '0;
    c(1'b1); c(1'b0); c(1'b0);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, i == n - 1, din[i], t);
      if (i < 32) dout[i] = t;
    end
    c(1'b1); c(1'b0);
  endtask

  initial begin
    logic [1:0]  cap;
    logic [31:0] w, dout;
    bit t;
    trst_n = 1'b1; u_if.TMS = 1'b1; u_if.TDI = 1'b0; u_if.bsc_tdo = 1'b0;
    @(posedge tck); #1;

    // Reset with random TMS, then hold in TLR.
    do_reset(2);
    c(1'b1); c(1'b1);

    // IDCODE (or bypass) read straight after reset.
    c(1'b0);
    w = $urandom();
    shift_dr(32, w, dout);
    check("idcode_read", dout, IdEn ? IdVal : {w[30:0], 1'b0});

    // EXTEST load; 17 boundary shifts.
    load_ir(4'b0000, cap);
    check("ir_capture", {30'd0, cap}, 32'h1);
    cnt_shift = 0; cnt_clock = 0; cnt_upd = 0;
    shift_dr(17, $urandom(), dout);
    check("shiftdr_cnt", cnt_shift, 17);
    check("clockdr_cnt", cnt_clock, 18);
    check("updatedr_cnt", cnt_upd, 1);

    // Five TMS=1 from Shift-DR (Mode stays 1 until TLR).
    c(1'b1); c(1'b0); c(1'b0);
    for (int i = 0; i < 5; i++) c(1'b1);
    c(1'b0);

    // From Pause-IR.
    load_ir(4'b0000, cap);
    c(1'b1); c(1'b1); c(1'b0); c(1'b1); c(1'b0); c(1'b0);
    for (int i = 0; i < 5; i++) c(1'b1);
    c(1'b0);

    // From Update-DR.
    load_ir(4'b0000, cap);
    c(1'b1); c(1'b0); c(1'b1); c(1'b1);
    for (int i = 0; i < 5; i++) c(1'b1);
    c(1'b0);

    // Bypass: TDI 1,0,1,1 -> TDO 0,1,0,1, no boundary strobes.
    load_ir(4'b1111, cap);
    cnt_shift = 0; cnt_clock = 0; cnt_upd = 0;
    shift_dr(4, 32'b1101, dout);
    check("bypass_tdo", dout[3:0], 4'b1010);
    check("bypass_strobes", cnt_shift + cnt_clock + cnt_upd, 0);

    // Reset in the middle of an EXTEST shift.
    load_ir(4'b0000, cap);
    c(1'b1); c(1'b0); c(1'b0); c(1'b0); c(1'b0);
    cyc(1'b0, 1'b0, 1'b1, t);
    c(1'b1); c(1'b0);

    // Random instruction/DR transactions.
    for (int k = 0; k < 40; k++) begin
      logic [3:0] op;
      case ($urandom_range(0, 4))
        0: op = 4'd0;
        1: op = 4'd1;
        2: op = 4'd2;
        3: op = 4'hF;
        default: op = 4'($urandom());
      endcase
      goto_rti();
      load_ir(op, cap);
      shift_dr($urandom_range(1, 20), $urandom(), dout);
    end

    // Random walk, occasional reset.
    for (int k = 0; k < 1500; k++) begin
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 1)), t);
    end

    @(negedge tck); #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
